// File: rtl/data_mem_if.sv
// Memory-stage bus between the core's M stage and the data memory unit.
// The core drives the access, the memory unit returns load data and status.
interface data_mem_if;
  logic        MemWriteM;
  logic [31:0] InstrM;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadDataM;
  logic [31:0] gpio_out;
  logic [2:0]  err_status;

  modport master (
    output MemWriteM, InstrM, Mem_WrAddr, Mem_WrData,
    input  ReadDataM, gpio_out, err_status
  );

  modport slave (
    input  MemWriteM, InstrM, Mem_WrAddr, Mem_WrData,
    output ReadDataM, gpio_out, err_status
  );
endinterface

// File: rtl/data_mem_unit.sv
// Load/store unit with byte-lane data RAM and a small MMIO window at 0xF000_0000
// (GPIO, cycle counter, committed-store counter, sticky W1C error status).
module data_mem_unit #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    REG_GPIO  = 2'd0,
    REG_CYCLE = 2'd1,
    REG_STORE = 2'd2,
    REG_ERR   = 2'd3
  } mmioReg_e;

  logic [31:0] mem [DEPTH];

  logic [31:0] gpioReg, cycleCnt, storeCnt;
  logic [2:0]  errReg, errSet, errNext;

  logic [2:0]        funct3;
  logic [31:0]       addr, wdata;
  logic [ADDR_W-1:0] wordIdx;
  mmioReg_e          regSel;
  logic isLoad, isStore, isMmio, aligned, mapOk, ldF3Ok, stF3Ok;
  logic ldValid, stValid, ramWe, mmioWe;
  logic [31:0] ramWord, ramLoad, mmioRead, wrLanes;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [3:0]  byteEn;

  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return !a[0];
      default: return a == 2'b00;
    endcase
  endfunction

  assign funct3  = bus.InstrM[14:12];
  assign addr    = bus.Mem_WrAddr;
  assign wdata   = bus.Mem_WrData;
  assign wordIdx = addr[ADDR_W+1:2];
  assign regSel  = mmioReg_e'(addr[3:2]);
  assign ramWord = mem[wordIdx];
  assign ldByte  = ramWord[{addr[1:0], 3'b000} +: 8];
  assign ldHalf  = ramWord[{addr[1], 4'b0000} +: 16];

  // Aliased RAM address bits and unused instruction fields.
  logic unusedBits;
  assign unusedBits = ^{addr[27:ADDR_W+2], bus.InstrM[31:15], bus.InstrM[11:7]};

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    isLoad  = bus.InstrM[6:0] == OP_LOAD;
    isStore = bus.MemWriteM;
    isMmio  = addr[31:28] == 4'hF;
    aligned = isAligned(funct3[1:0], addr[1:0]);
    mapOk   = !isMmio || (addr[27:4] == '0);
    // MMIO accepts word accesses only.
    ldF3Ok  = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
              && (!isMmio || funct3 == 3'b010);
    stF3Ok  = (funct3 inside {3'b000, 3'b001, 3'b010})
              && (!isMmio || funct3 == 3'b010);
    ldValid = isLoad  && ldF3Ok && aligned && mapOk;
    stValid = isStore && stF3Ok && aligned && mapOk;
    // Gating with reset here blocks RAM writes while reset is held.
    ramWe   = stValid && !isMmio && reset;
    mmioWe  = stValid && isMmio;

    errSet    = '0;
    errSet[0] = isLoad  && ldF3Ok && !aligned;
    errSet[1] = isStore && stF3Ok && !aligned;
    errSet[2] = (isLoad  && (!ldF3Ok || (aligned && !mapOk)))
             || (isStore && (!stF3Ok || (aligned && !mapOk)));

    errNext = errReg;
    if (mmioWe && regSel == REG_ERR) errNext = errReg & ~wdata[2:0];
    errNext = errNext | errSet;

    case (funct3)
      3'b000:  ramLoad = {{24{ldByte[7]}}, ldByte};
      3'b001:  ramLoad = {{16{ldHalf[15]}}, ldHalf};
      3'b010:  ramLoad = ramWord;
      3'b100:  ramLoad = {24'h0, ldByte};
      3'b101:  ramLoad = {16'h0, ldHalf};
      default: ramLoad = '0;
    endcase

    case (regSel)
      REG_GPIO:  mmioRead = gpioReg;
      REG_CYCLE: mmioRead = cycleCnt;
      REG_STORE: mmioRead = storeCnt;
      default:   mmioRead = {29'h0, errReg};
    endcase

    case (funct3[1:0])
      2'b00: begin
        wrLanes = {4{wdata[7:0]}};
        byteEn  = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wrLanes = {2{wdata[15:0]}};
        byteEn  = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wrLanes = wdata;
        byteEn  = 4'b1111;
      end
    endcase
  end

  assign bus.ReadDataM  = ldValid ? (isMmio ? mmioRead : ramLoad) : 32'h0;
  assign bus.gpio_out   = gpioReg;
  assign bus.err_status = errReg;

  // NOTE: RAM contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrLanes[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpioReg  <= '0;
      cycleCnt <= '0;
      storeCnt <= '0;
      errReg   <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (ramWe) storeCnt <= storeCnt + 32'd1;
      if (mmioWe && regSel == REG_GPIO) gpioReg <= wdata;
      errReg <= errNext;
    end
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Memory-stage load/store unit and data RAM fed by the pipelined core's M-stage outputs: Mem_WrAddr, Mem_WrData, MemWriteM and InstrM.
- Returns the sign- or zero-extended load word ReadDataM to the core, combinationally in the same cycle. The core registers it into the M/W register.
- Implements byte-lane stores.
- Adds a small MMIO window at 0xF000_0000 with:
  - GPIO output register
  - free-running cycle counter
  - committed-store counter
  - sticky error status register

Parameters:
DEPTH, 1024, number of 32-bit RAM words (power of two)
ADDR_W, 10, log2(DEPTH); RAM word index = Mem_WrAddr[ADDR_W+1:2]

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
MemWriteM  in  1  store strobe from M stage
InstrM  in  32  M-stage instruction; opcode [6:0], funct3 [14:12]
Mem_WrAddr  in  32  byte address (ALUResultM)
Mem_WrData  in  32  store data, lane-0 aligned (rs2 value)
ReadDataM  out  32  extended load result (combinational)
gpio_out  out  32  GPIO output register
err_status  out  3  sticky error flags {range/illegal, mis_store, mis_load}

Behaviour:
- Access decode:
  - load = (InstrM[6:0]==7'b0000011)
  - store = MemWriteM
  - MMIO when Mem_WrAddr[31:28]==4'hF, else RAM
- RAM is not reset. Reads are asynchronous; writes are synchronous on clk.
- Load formats:
  - funct3 000 LB (sign-extend byte at addr[1:0])
  - 001 LH (sign-extend half at addr[1])
  - 010 LW
  - 100 LBU, 101 LHU (zero-extend)
- Store formats:
  - 000 SB: write Mem_WrData[7:0] to lane addr[1:0]
  - 001 SH: write Mem_WrData[15:0] to half addr[1]
  - 010 SW
  - Unaddressed lanes keep their old contents.
- Alignment:
  - LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - Misaligned load: ReadDataM=0, set err bit0 at next edge.
  - Misaligned store: write suppressed, set err bit1.
- Illegal funct3 (load 011/110/111; store 011-111):
  - access suppressed, ReadDataM=0, set err bit2
- RAM address bits [29:ADDR_W+2] are ignored (aliasing). No range error in RAM space.
- MMIO map (word access only; any non-LW/SW MMIO access is suppressed, reads 0, sets bit2):
  - 0xF000_0000 GPIO_OUT: RW
  - 0xF000_0004 CYCLE_CNT: RO
  - 0xF000_0008 STORE_CNT: RO
  - 0xF000_000C ERR_STATUS: bits[2:0], upper bits read 0; write-1-to-clear
  - Any other 0xFxxx_xxxx: reads 0, writes ignored, set bit2
  - Stores to RO registers are ignored; no error.
- CYCLE_CNT: +1 every clock when not in reset; wraps 0xFFFF_FFFF -> 0.
- STORE_CNT:
  - +1 per committed RAM store (after alignment/funct3 checks); wraps.
  - MMIO stores do not count.
- Reading CYCLE_CNT returns the pre-edge value (value held during that cycle).
- Simultaneous events: a W1C write to ERR_STATUS and a new error on the same bit in the same cycle -> bit ends set (set wins).
- Load and store both active (should not occur): store takes effect; ReadDataM still follows the load rules.
- Reset (reset==0, any time incl. mid-operation), asynchronously:
  - gpio_out=0, CYCLE_CNT=0, STORE_CNT=0, err_status=0
  - RAM writes blocked while reset==0
- ReadDataM is 0 whenever neither load opcode nor a valid access is present; its value is don't-care outside loads.
- Latency: store visible to a load in the following cycle; no forwarding within the same cycle.

Test Plan:
- Byte-lane stores then loads:
  - SW 0x8000_00FF @0x10
  - SB 0x5A @0x12
  - LW @0x10 -> 0x805A_00FF
  - LB @0x13 -> 0xFFFF_FF80
  - LBU @0x13 -> 0x0000_0080
- Halfword stores then loads:
  - SH 0xBEEF @0x22
  - LH @0x22 -> 0xFFFF_BEEF
  - LHU @0x22 -> 0x0000_BEEF
  - LW @0x20 -> upper half 0xBEEF, lower half unchanged
- Misaligned accesses:
  - SW @0x31 -> RAM word 0x30 unchanged, err_status=3'b010
  - LH @0x41 -> ReadDataM=0, err_status=3'b011
  - SW 0x1 to 0xF000_000C -> err_status=3'b010
- MMIO and counters:
  - SW 0xA5A5 to 0xF000_0000 -> gpio_out=0x0000_A5A5 next cycle
  - LW 0xF000_0008 after 3 RAM stores -> 3
  - Two LW 0xF000_0004 N cycles apart differ by N
- Illegal access and set-wins:
  - LB 0xF000_0000 -> ReadDataM=0, bit2 set
  - Same cycle as a W1C of bit2 with an illegal funct3 store -> bit2 stays 1
- Reset mid-operation:
  - Assert reset low between edges while MemWriteM=1 -> outputs/counters 0 immediately, RAM word not written
  - Release -> CYCLE_CNT restarts from 0
